// File: rtl/keccak_sequencer_if.sv
// Handshake/strobe bundle between padder, user-input snoop and the Keccak sequencer.
// The master side drives padder/user status; the slave side (sequencer) drives datapath strobes.
interface keccak_sequencer_if #(
  parameter int RW = 5
);
  logic          in_ready;
  logic          is_last;
  logic          buffer_full;
  logic          pad_ready;
  logic          f_ack;
  logic          absorb;
  logic          round_en;
  logic [RW-1:0] round_idx;
  logic          busy;
  logic          out_ready;

  modport master (
    output in_ready, is_last, buffer_full, pad_ready,
    input  f_ack, absorb, round_en, round_idx, busy, out_ready
  );

  modport slave (
    input  in_ready, is_last, buffer_full, pad_ready,
    output f_ack, absorb, round_en, round_idx, busy, out_ready
  );
endinterface

// File: rtl/keccak_sequencer.sv
// Sequences absorb + ROUNDS permutation rounds per padder block; raises sticky out_ready after the final block.
// All outputs are registered decodes of the next state, so nothing is combinational from inputs.
module keccak_sequencer #(
  parameter int ROUNDS = 24,
  parameter int RW     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  keccak_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} state_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          last_seen_q, last_seen_d;
  logic          last_dly_q, last_dly_d;
  logic          blk_seen_q, blk_seen_d;
  logic          f_ack_q, f_ack_d;
  logic          absorb_q, absorb_d;
  logic          round_en_q, round_en_d;
  logic          busy_q, busy_d;
  logic          out_ready_q, out_ready_d;

  always_comb begin
    state_d     = state_q;
    round_d     = '0;
    blk_seen_d  = blk_seen_q;
    // Sticky: once set, further user pulses cannot change anything.
    last_seen_d = last_seen_q | (bus.in_ready & bus.is_last & ~bus.buffer_full);
    last_dly_d  = last_seen_q;

    case (state_q)
      IDLE: begin
        // A pending block always wins over finishing, covering two-block padding.
        if (bus.pad_ready) begin
          state_d = ABSORB;
        end else if (last_dly_q && blk_seen_q) begin
          state_d = DONE;
        end
      end
      ABSORB: begin
        blk_seen_d = 1'b1;
        state_d    = PERM;
      end
      PERM: begin
        if (round_q == LAST_ROUND) begin
          state_d = bus.pad_ready ? ABSORB : IDLE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    f_ack_d     = (state_d == ABSORB);
    absorb_d    = (state_d == ABSORB);
    round_en_d  = (state_d == PERM);
    busy_d      = (state_d == ABSORB) || (state_d == PERM);
    out_ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      last_seen_q <= 1'b0;
      last_dly_q  <= 1'b0;
      blk_seen_q  <= 1'b0;
      f_ack_q     <= 1'b0;
      absorb_q    <= 1'b0;
      round_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      last_seen_q <= last_seen_d;
      last_dly_q  <= last_dly_d;
      blk_seen_q  <= blk_seen_d;
      f_ack_q     <= f_ack_d;
      absorb_q    <= absorb_d;
      round_en_q  <= round_en_d;
      busy_q      <= busy_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign bus.f_ack     = f_ack_q;
  assign bus.absorb    = absorb_q;
  assign bus.round_en  = round_en_q;
  assign bus.round_idx = round_q;
  assign bus.busy      = busy_q;
  assign bus.out_ready = out_ready_q;
endmodule

// File: tb/tb_keccak_sequencer.sv
// Scoreboard bench for keccak_sequencer: per-cycle expected strobe vectors queued with the stimulus.
// Outputs are sampled on the falling edge; inputs for the next rising edge are driven right after.
module tb_keccak_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  keccak_sequencer_if #(.RW(5)) bus ();
  keccak_sequencer_if #(.RW(2)) bus4 ();

  keccak_sequencer #(.ROUNDS(24), .RW(5)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  keccak_sequencer #(.ROUNDS(4),  .RW(2)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // Expected vector: {f_ack, absorb, round_en, busy, out_ready, round_idx[4:0]}
  // Stimulus vector: {in_ready, is_last, buffer_full, pad_ready}
  logic [9:0] exp_q[$];
  logic [3:0] stim_q[$];
  logic [9:0] exp_v, obs_v;
  logic [3:0] st_v;
  int         cyc;

  localparam logic [3:0] S_PAD  = 4'b0001;
  localparam logic [3:0] S_LAST = 4'b1100;
  localparam logic [3:0] S_FULL = 4'b1110;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(10'b0);
  endtask

  task automatic push_absorb();
    exp_q.push_back({5'b11010, 5'd0});
  endtask

  task automatic push_rounds(input int nr);
    for (int r = 0; r < nr; r++) exp_q.push_back({5'b00110, 5'(r)});
  endtask

  task automatic push_done(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({5'b00001, 5'd0});
  endtask

  task automatic fill_stim();
    stim_q.delete();
    for (int i = 0; i < exp_q.size(); i++) stim_q.push_back(4'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = 4'b0;
    {bus4.in_ready, bus4.is_last, bus4.buffer_full, bus4.pad_ready} = 4'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = 4'b0;
    {bus4.in_ready, bus4.is_last, bus4.buffer_full, bus4.pad_ready} = 4'b0;
    #3 reset = 1'b1;
    #1;
    obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
    total++;
    if (obs_v !== 10'b0) begin
      bad++;
      $display("FAIL reset_r24 got=%b want=%b", obs_v, 10'b0);
    end
    obs_v = {bus4.f_ack, bus4.absorb, bus4.round_en, bus4.busy, bus4.out_ready, 3'b0, bus4.round_idx};
    total++;
    if (obs_v !== 10'b0) begin
      bad++;
      $display("FAIL reset_r4 got=%b want=%b", obs_v, 10'b0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Shared timeline for the empty-message and extra-input cases.
  task automatic build_empty();
    exp_q.delete();
    push_idle(9);
    push_absorb();
    push_rounds(24);
    push_idle(1);
    push_done(12);
    fill_stim();
    stim_q[7] = S_LAST;
    stim_q[8] = S_PAD;
  endtask

  task automatic test_empty_message();
    do_reset();
    build_empty();
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL empty_msg cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = st_v;
      cyc++;
    end
  endtask

  task automatic test_extra_after_last();
    do_reset();
    build_empty();
    stim_q[12] = S_LAST;
    stim_q[20] = S_LAST;
    stim_q[34] = S_LAST;
    stim_q[36] = S_LAST;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL extra_last cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = st_v;
      cyc++;
    end
  endtask

  // Two blocks with no IDLE gap, then a last word refused by a full buffer must not finish.
  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    push_idle(1);
    push_absorb();
    push_rounds(24);
    push_absorb();
    push_rounds(24);
    push_idle(8);
    fill_stim();
    for (int i = 0; i <= 25; i++) stim_q[i] = S_PAD;
    stim_q[52] = S_FULL;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = st_v;
      cyc++;
    end
  endtask

  task automatic test_two_block_padding();
    do_reset();
    exp_q.delete();
    push_idle(1);
    push_absorb();
    push_rounds(24);
    push_absorb();
    push_rounds(24);
    push_idle(1);
    push_done(6);
    fill_stim();
    stim_q[0] = S_LAST | S_PAD;
    for (int i = 2; i <= 25; i++) stim_q[i] = S_PAD;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL two_block cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = st_v;
      cyc++;
    end
  endtask

  task automatic test_reset_mid_perm();
    do_reset();
    exp_q.delete();
    push_idle(1);
    push_absorb();
    push_rounds(11);
    fill_stim();
    stim_q[0] = S_PAD;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL mid_perm_pre cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = st_v;
      cyc++;
    end
    #2 reset = 1'b1;
    #1;
    obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
    total++;
    if (obs_v !== 10'b0) begin
      bad++;
      $display("FAIL mid_perm_async got=%b want=%b", obs_v, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    push_absorb();
    push_rounds(3);
    fill_stim();
    stim_q[0] = 4'b0;
    bus.pad_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus.f_ack, bus.absorb, bus.round_en, bus.busy, bus.out_ready, bus.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL mid_perm_restart cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus.in_ready, bus.is_last, bus.buffer_full, bus.pad_ready} = st_v;
      cyc++;
    end
  endtask

  task automatic test_rounds4();
    do_reset();
    exp_q.delete();
    push_idle(1);
    push_absorb();
    push_rounds(4);
    push_absorb();
    push_rounds(4);
    push_idle(2);
    fill_stim();
    stim_q[0] = S_PAD;
    stim_q[5] = S_PAD;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      st_v  = stim_q.pop_front();
      obs_v = {bus4.f_ack, bus4.absorb, bus4.round_en, bus4.busy, bus4.out_ready, 3'b0, bus4.round_idx};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL rounds4 cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
      {bus4.in_ready, bus4.is_last, bus4.buffer_full, bus4.pad_ready} = st_v;
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_empty_message();
    test_back_to_back();
    test_two_block_padding();
    test_extra_after_last();
    test_reset_mid_perm();
    test_rounds4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keccak_sequencer.md
# keccak_sequencer

Control sequencer between the SHA-3 padder and the Keccak-f permutation datapath. It takes 576-bit blocks from the padder, orders the datapath to XOR-absorb each block and run ROUNDS permutation rounds, and snoops the user input handshake to find the end of the message. Once the final padded block has been permuted, it raises a sticky out_ready. It holds no data; it emits only handshake and strobe signals.

## Interface
- ROUNDS, 24, number of permutation rounds per block (2..31)
- RW, 5, width of round_idx; must satisfy 2^RW >= ROUNDS
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_ready  in  1  user word strobe to padder (snooped)
- is_last  in  1  user last-word flag to padder (snooped)
- buffer_full  in  1  padder cannot accept a word this cycle
- pad_ready  in  1  padder holds a complete 576-bit block (padder out_ready)
- f_ack  out  1  one-cycle pulse: padder block consumed
- absorb  out  1  one-cycle pulse: datapath state <= state ^ block
- round_en  out  1  datapath applies round round_idx this cycle
- round_idx  out  RW  current round number, 0..ROUNDS-1
- busy  out  1  state is ABSORB or PERM
- out_ready  out  1  digest valid; sticky until reset

## Operation
- States: IDLE, ABSORB, PERM, DONE. Reset state is IDLE.
- IDLE:
  - if pad_ready=1, go to ABSORB;
  - else if last_d=1 and blk_seen=1, go to DONE;
  - else stay in IDLE.
- ABSORB: lasts exactly one cycle, with f_ack=1, absorb=1 and round_idx=0. Sets blk_seen. Next state is PERM.
- PERM: round_en=1. round_idx increments by 1 each cycle from 0.
  - At round_idx=ROUNDS-1: go to ABSORB if pad_ready=1, else go to IDLE. round_idx returns to 0.
- DONE: out_ready=1 and all strobes are 0. pad_ready is ignored. The block leaves DONE only on reset.
- last_seen: set on the clock edge where in_ready=1, is_last=1 and buffer_full=0. It stays set until reset.
- last_d: last_seen delayed by one cycle. This gives the padder one cycle to raise pad_ready for the final block.
- The padder contract requires pad_ready to rise no later than the edge after it accepts the last word. The one-cycle last_d guard makes two-block padding safe: if the final block is still pending, IDLE absorbs it first.
- Inputs to the snoop logic are ignored once last_seen is set. A further in_ready/is_last pulse has no effect.
- busy = (state==ABSORB || state==PERM).
- round_idx is held at 0 outside PERM.
- No arithmetic wider than RW. round_idx never exceeds ROUNDS-1 and does not wrap through 2^RW.

## Timing
- Reset values: f_ack=0, absorb=0, round_en=0, round_idx=0, busy=0, out_ready=0, last_seen=0, last_d=0, blk_seen=0.
- All outputs are registered state decodes. None is combinational from inputs.
- Single block, starting in IDLE:
  - pad_ready sampled 1 at edge E;
  - ABSORB occupies cycle E..E+1;
  - rounds 0..ROUNDS-1 occupy the next ROUNDS cycles;
  - IDLE is re-entered after 1+ROUNDS cycles.
- Back-to-back blocks: one block every ROUNDS+1 cycles; there is no IDLE gap when pad_ready=1 at the last round.
- f_ack is exactly one cycle per block. The padder drops pad_ready on the edge after f_ack, so a block is never double-acknowledged.
- out_ready rises on the edge after the IDLE cycle in which last_d=1, blk_seen=1 and pad_ready=0.
- Simultaneous events:
  - pad_ready=1 and the DONE condition in the same IDLE cycle: ABSORB wins.
  - last word accepted during PERM: the rounds continue unaffected.
- Reset mid-PERM or mid-ABSORB: everything returns to IDLE at once and all outputs go to 0. A partial round count is discarded.

## Test plan
- Empty message: reset, wait 7 cycles, then one cycle of in_ready=1, is_last=1 with buffer_full=0. Padder model raises pad_ready on the next edge. Required response:
  - one f_ack/absorb pulse;
  - 24 round_en cycles with round_idx 0..23;
  - IDLE, then out_ready=1 one edge later, held for 10+ cycles.
- Two blocks back to back: pad_ready held 1 through the first permutation. Required: f_ack pulses exactly 25 cycles apart, with no IDLE cycle between round 23 and the second ABSORB.
- Two-block padding: the last word is accepted while pad_ready=1 for block A; the padder model raises pad_ready for block B after A's f_ack. Required: both blocks are absorbed and out_ready rises only after B's round 23.
- Extra input after last: in_ready=1, is_last=1 pulsed again after last_seen. Required: no change; out_ready timing is identical to the empty-message case.
- Reset at round_idx=10: assert reset asynchronously between edges. Required: all outputs read 0 immediately. After release, with pad_ready=1, a fresh ABSORB occurs and the rounds restart at 0.
- Parameter check ROUNDS=4, RW=2: single block. Required: round_idx 0,1,2,3 and a 5-cycle block period.
